// File: rtl/imem_loader_if.sv
// Boot-loader bundle: the byte-stream handshake in, the instruction-memory write port out,
// and the core reset and status flags. The loader uses the slave view; the stream host uses master.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_rst;
    logic        load_done;
    logic        load_err;

    modport master (
        output in_valid, in_data,
        input  in_ready, im_we, im_addr, im_wdata, cpu_rst, load_done, load_err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, im_we, im_addr, im_wdata, cpu_rst, load_done, load_err
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction loader: parses a length-prefixed, XOR-checksummed byte stream into
// big-endian words, writes them from TEXT_BASE upward, and releases the core only on a good image.
module imem_loader #(
    parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
    parameter int          IMEM_DEPTH = 1024
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,
        S_HDR1 = 3'd1,
        S_LOAD = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  n_hi_r;
    logic [15:0] n_r;
    logic [15:0] word_cnt_r;
    logic [1:0]  byte_cnt_r;
    logic [23:0] asm_r;
    logic [7:0]  csum_r;
    logic        im_we_r;
    logic [31:0] im_addr_r;
    logic [31:0] im_wdata_r;
    logic        cpu_rst_r;
    logic        load_done_r;
    logic        load_err_r;
    logic        in_ready_s;
    logic        accept_s;
    logic [15:0] n_s;
    logic        word_end_s;
    logic        last_word_s;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    function automatic logic [31:0] word_addr(input logic [15:0] k);
        return TEXT_BASE + {14'd0, k, 2'b00};
    endfunction

    // Next-state decode and the ready/accept strobes derived from the current state.
    always_comb begin
        n_s         = {n_hi_r, bus.in_data};
        word_end_s  = (byte_cnt_r == 2'd3);
        last_word_s = (word_cnt_r == (n_r - 16'd1));
        in_ready_s  = 1'b0;
        state_nxt_s = state_r;
        case (state_r)
            S_HDR0, S_HDR1, S_LOAD, S_CSUM: in_ready_s = 1'b1;
            default:                        in_ready_s = 1'b0;
        endcase
        accept_s = bus.in_valid & in_ready_s;
        case (state_r)
            S_HDR0: begin
                if (accept_s) state_nxt_s = S_HDR1;
                else          state_nxt_s = S_HDR0;
            end
            S_HDR1: begin
                if (accept_s) begin
                    if ({16'd0, n_s} > DEPTH_W) state_nxt_s = S_ERR;
                    else if (n_s == 16'd0)      state_nxt_s = S_CSUM;
                    else                        state_nxt_s = S_LOAD;
                end else begin
                    state_nxt_s = S_HDR1;
                end
            end
            S_LOAD: begin
                if (accept_s && word_end_s && last_word_s) state_nxt_s = S_CSUM;
                else                                       state_nxt_s = S_LOAD;
            end
            S_CSUM: begin
                if (accept_s) begin
                    if (bus.in_data == csum_r) state_nxt_s = S_DONE;
                    else                       state_nxt_s = S_ERR;
                end else begin
                    state_nxt_s = S_CSUM;
                end
            end
            S_DONE:  state_nxt_s = S_DONE;
            S_ERR:   state_nxt_s = S_ERR;
            // Unused encodings fall to ERR so the core stays held in reset.
            default: state_nxt_s = S_ERR;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_r <= S_HDR0;
        else      state_r <= state_nxt_s;
    end

    // Header latch, word assembly, checksum, write port and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            n_hi_r      <= 8'd0;
            n_r         <= 16'd0;
            word_cnt_r  <= 16'd0;
            byte_cnt_r  <= 2'd0;
            asm_r       <= 24'd0;
            csum_r      <= 8'd0;
            im_we_r     <= 1'b0;
            im_addr_r   <= TEXT_BASE;
            im_wdata_r  <= 32'd0;
            cpu_rst_r   <= 1'b1;
            load_done_r <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            im_we_r     <= 1'b0;
            // Flags follow the next state so they change exactly one cycle after the deciding byte.
            cpu_rst_r   <= (state_nxt_s != S_DONE);
            load_done_r <= (state_nxt_s == S_DONE);
            load_err_r  <= (state_nxt_s == S_ERR);
            if (accept_s) begin
                case (state_r)
                    S_HDR0: n_hi_r <= bus.in_data;
                    S_HDR1: n_r    <= n_s;
                    S_LOAD: begin
                        csum_r     <= csum_update(csum_r, bus.in_data);
                        asm_r      <= {asm_r[15:0], bus.in_data};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (word_end_s) begin
                            im_we_r    <= 1'b1;
                            im_wdata_r <= {asm_r, bus.in_data};
                            im_addr_r  <= word_addr(word_cnt_r);
                            word_cnt_r <= word_cnt_r + 16'd1;
                        end else begin
                            im_we_r    <= 1'b0;
                        end
                    end
                    default: im_we_r <= 1'b0;
                endcase
            end else begin
                im_we_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.im_we     = im_we_r;
    assign bus.im_addr   = im_addr_r;
    assign bus.im_wdata  = im_wdata_r;
    assign bus.cpu_rst   = cpu_rst_r;
    assign bus.load_done = load_done_r;
    assign bus.load_err  = load_err_r;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a byte-level image model predicts writes and outcome,
// a negedge monitor pops expected writes whenever the loader pulses im_we.
module tb_imem_loader;
    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int          DEPTH = 1024;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    imem_loader_if bus();

    imem_loader #(.TEXT_BASE(BASE), .IMEM_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    wr_t        exp_q[$];
    logic [7:0] stream[$];
    logic       prev_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every im_we pulse must match the oldest expected write and last one cycle.
    always @(negedge clk) begin
        if (bus.im_we === 1'b1) begin
            check("im_we_single_cycle", 32'(prev_we), 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                         bus.im_addr, bus.im_wdata);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("im_addr", bus.im_addr, w.addr);
                check("im_wdata", bus.im_wdata, w.data);
            end
        end
        prev_we <= (bus.im_we === 1'b1);
    end

    // Reference: how many bytes the loader takes and whether the image is good.
    function automatic void model(input logic [7:0] s[$], output int consumed, output bit ok);
        int         n;
        logic [7:0] x;
        n = int'({s[0], s[1]});
        if (n > DEPTH) begin
            consumed = 2;
            ok = 1'b0;
            return;
        end
        consumed = 2 + 4 * n + 1;
        x = 8'd0;
        for (int i = 2; i < 2 + 4 * n; i++) x = x ^ s[i];
        ok = (s[consumed - 1] == x);
    endfunction

    task automatic build(input int n, input bit corrupt, input int extras);
        logic [7:0] x;
        logic [7:0] b;
        logic [15:0] n16;
        n16 = 16'(n);
        stream.delete();
        stream.push_back(n16[15:8]);
        stream.push_back(n16[7:0]);
        x = 8'd0;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom_range(0, 255));
            stream.push_back(b);
            x = x ^ b;
        end
        if (corrupt) x = x ^ 8'($urandom_range(1, 255));
        stream.push_back(x);
        for (int i = 0; i < extras; i++) stream.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst_im_we", 32'(bus.im_we), 32'd0);
        check("rst_im_addr", bus.im_addr, BASE);
        check("rst_im_wdata", bus.im_wdata, 32'd0);
        check("rst_cpu_rst", 32'(bus.cpu_rst), 32'd1);
        check("rst_load_done", 32'(bus.load_done), 32'd0);
        check("rst_load_err", 32'(bus.load_err), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic send(input int limit, input bit gaps);
        int  consumed;
        bit  ok;
        int  k;
        wr_t w;
        model(stream, consumed, ok);
        for (int i = 0; i < stream.size() && i < limit; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                    if (i < consumed) check("in_ready_in_gap", 32'(bus.in_ready), 32'd1);
                end
            end
            bus.in_valid = 1'b1;
            bus.in_data  = stream[i];
            if (i < consumed) begin
                check("in_ready_loading", 32'(bus.in_ready), 32'd1);
                check("cpu_rst_held", 32'(bus.cpu_rst), 32'd1);
                if (i >= 2 && i < consumed - 1 && ((i - 2) % 4) == 3) begin
                    k = (i - 2) / 4;
                    w.addr = BASE + 32'(4 * k);
                    w.data = {stream[i - 3], stream[i - 2], stream[i - 1], stream[i]};
                    exp_q.push_back(w);
                end
            end else begin
                check("in_ready_terminal", 32'(bus.in_ready), 32'd0);
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            if (i == consumed - 1) begin
                check("load_done", 32'(bus.load_done), 32'(ok));
                check("load_err", 32'(bus.load_err), 32'(!ok));
                check("cpu_rst_after", 32'(bus.cpu_rst), 32'(!ok));
                check("in_ready_after", 32'(bus.in_ready), 32'd0);
            end
        end
    endtask

    task automatic load_case1(input logic [7:0] cs, input int extras);
        logic [7:0] c1[10];
        c1 = '{8'h00, 8'h02, 8'h20, 8'h10, 8'h00, 8'h05, 8'h20, 8'h11, 8'h00, 8'h0C};
        stream.delete();
        foreach (c1[i]) stream.push_back(c1[i]);
        stream.push_back(cs);
        for (int i = 0; i < extras; i++) stream.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        do_reset();

        load_case1(8'h08, 4);
        send(stream.size(), 1'b0);

        do_reset();
        load_case1(8'h09, 4);
        send(stream.size(), 1'b0);

        do_reset();
        stream = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send(stream.size(), 1'b0);

        do_reset();
        stream = '{8'h04, 8'h01, 8'h20, 8'h10, 8'h00, 8'h05};
        send(stream.size(), 1'b0);

        do_reset();
        load_case1(8'h08, 0);
        send(stream.size(), 1'b1);

        do_reset();
        load_case1(8'h08, 0);
        send(7, 1'b0);
        do_reset();
        send(stream.size(), 1'b0);

        do_reset();
        build(DEPTH, 1'b0, 2);
        send(stream.size(), 1'b0);

        do_reset();
        build(DEPTH + 1, 1'b0, 0);
        send(6, 1'b0);

        for (int t = 0; t < 10; t++) begin
            do_reset();
            build($urandom_range(0, 8), ($urandom_range(0, 2) == 0), $urandom_range(0, 4));
            send(stream.size(), ($urandom_range(0, 1) == 1));
        end

        do_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction loader that sits directly upstream of the `mips` core. It accepts a byte stream over a valid/ready handshake, checks a length header and an XOR checksum, and assembles big-endian 32-bit words. It writes each word into the core's instruction memory starting at the text base, and holds the core in reset until the image is loaded and verified.

## Interface
- `TEXT_BASE`, default 32'h0000_3000: byte address of the first instruction word.
- `IMEM_DEPTH`, default 1024: instruction memory capacity in words; the largest legal word count.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset (sampled on rising edge of `clk`).
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `im_we`  out  1  instruction-memory write enable, one-cycle pulse.
- `im_addr`  out  32  byte address of write (word aligned).
- `im_wdata`  out  32  instruction word.
- `cpu_rst`  out  1  active-high reset to the core.
- `load_done`  out  1  image loaded and checksum matched (sticky).
- `load_err`  out  1  header or checksum error (sticky).

## Operation
- Stream format: `N[15:8]`, `N[7:0]` (word count), then 4·N payload bytes (each word MSB first), then 1 checksum byte. The checksum is the XOR of all payload bytes; header bytes are excluded.
- A byte is accepted on an edge where `in_valid && in_ready`.
- States: HDR0 → HDR1 → LOAD → CSUM → DONE; ERR is reachable from HDR1 or CSUM.
  - HDR0: accept byte, latch `N[15:8]`.
  - HDR1: accept byte, form N.
    - N > IMEM_DEPTH → ERR.
    - N == 0 → CSUM.
    - Otherwise → LOAD.
  - LOAD: shift bytes into a 32-bit assembly register and XOR each into the running checksum.
    - On the 4th byte of a word, register `im_we`=1, `im_wdata`=assembled word, `im_addr`=TEXT_BASE + 4·k, where k is the 0-based word index.
    - After word N-1 → CSUM.
  - CSUM: accept byte.
    - Equal to the running XOR → DONE.
    - Otherwise → ERR.
  - DONE: `in_ready`=0, `load_done`=1, `cpu_rst`=0. Terminal until reset.
  - ERR: `in_ready`=0, `load_err`=1, `cpu_rst`=1. Terminal until reset.
- `in_ready` is 1 exactly in HDR0, HDR1, LOAD and CSUM, and is decoded from the state register.
- Word counter: 16 bits, compared against N. Address arithmetic is 32-bit, and the address never exceeds TEXT_BASE + 4·(IMEM_DEPTH−1).
- Bytes presented in DONE or ERR are not accepted and have no effect.

## Timing
- Reset (`rst`=0 at an edge) gives:
  - state HDR0; `im_we`=0, `im_addr`=TEXT_BASE, `im_wdata`=0.
  - `cpu_rst`=1, `load_done`=0, `load_err`=0.
  - Checksum, word counter and byte counter cleared.
- Reset mid-load discards any partial word and the count. The next image restarts at TEXT_BASE.
- Write latency: the 4th byte of a word is accepted at edge E. `im_we`, `im_addr` and `im_wdata` are valid in the cycle after E, and memory captures the word at edge E+1. `im_we` is 0 in every other cycle.
- The checksum byte is accepted at edge C. `load_done`/`cpu_rst`=0 (or `load_err`=1) take effect from the cycle after C.
  - The last `im_we` pulse never overlaps the first cycle with `cpu_rst`=0, because the checksum byte is accepted at the earliest on the edge where the last word is written.
  - The core fetches from TEXT_BASE starting at edge C+1.
- Throughput: one byte per cycle with `in_valid` held high. Bubbles (`in_valid`=0) stall without side effects.
- `cpu_rst` is 1 from reset through C inclusive, with no glitches.

## Test plan
- N=2, payload 20 10 00 05 20 11 00 0C, checksum 08 ->
  - `im_we` pulses twice: 0x3000←0x20100005, then 0x3004←0x2011000C.
  - `load_done`=1 and `cpu_rst`=0 one cycle after the checksum byte; `in_ready`=0 afterwards.
- Same stream with checksum 09 -> both writes occur, then `load_err`=1, `cpu_rst` stays 1, `load_done`=0, `in_ready`=0. Further bytes are ignored.
- Header 00 00, checksum 00 -> no `im_we`, `load_done`=1 after the 3rd byte.
- Header 04 01 (1025 > IMEM_DEPTH) -> `load_err`=1 after the 2nd byte, no `im_we`, `in_ready`=0.
- N=2 stream with random `in_valid` gaps of 0–3 cycles -> identical writes and addresses as case 1. Each `im_we` is exactly one cycle, and `in_ready` stays 1 until the checksum byte.
- Assert `rst`=0 for one edge after 5 payload bytes of case 1, then resend the full case-1 stream ->
  - No write for the discarded partial word.
  - Writes restart at 0x3000 and `load_done`=1 at the end.
